// File: rtl/mips_datapath_if.sv
// Bundle between the MIPS datapath and its controller/memory side: control
// strobes, instruction and data-memory words in, datapath status and addresses out.
interface mips_datapath_if;
  logic        regdst;
  logic        pcsrc;
  logic        memtoreg;
  logic        alusrc;
  logic        regwrite;
  logic        jump;
  logic [3:0]  alucontrol;
  logic [31:0] instr;
  logic [31:0] readdata;
  logic        zero;
  logic [31:0] pc;
  logic [31:0] aluout;
  logic [31:0] writedata;

  modport master (
    output regdst, pcsrc, memtoreg, alusrc, regwrite, jump, alucontrol,
    output instr, readdata,
    input  zero, pc, aluout, writedata
  );

  modport slave (
    input  regdst, pcsrc, memtoreg, alusrc, regwrite, jump, alucontrol,
    input  instr, readdata,
    output zero, pc, aluout, writedata
  );
endinterface

// File: rtl/mips_datapath.sv
// Single-cycle MIPS-style 32-bit datapath: PC and next-PC logic, 32x32 register
// file, sign extender, ALU and writeback mux; memories and control live outside.
module mips_datapath (
  input  logic           clk,
  input  logic           reset,
  mips_datapath_if.slave bus
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  logic [31:0] r_pc;
  logic [31:0] r_rf [32];

  logic [4:0]  w_ra1;
  logic [4:0]  w_ra2;
  logic [4:0]  w_wa;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;
  logic [31:0] w_signimm;
  logic [31:0] w_srcb;
  logic [31:0] w_alu;
  logic [31:0] w_result;
  logic [31:0] w_pcplus4;
  logic [31:0] w_pcbranch;
  logic [31:0] w_pcjump;
  logic [31:0] w_pcnext;
  logic        w_unused_opcode;

  // The opcode field is decoded by the controller, not here.
  assign w_unused_opcode = ^bus.instr[31:26];

  assign w_ra1     = bus.instr[25:21];
  assign w_ra2     = bus.instr[20:16];
  assign w_wa      = bus.regdst ? bus.instr[15:11] : bus.instr[20:16];
  assign w_signimm = {{16{bus.instr[15]}}, bus.instr[15:0]};

  // Asynchronous reads; the explicit r0 check keeps register 0 hard-wired.
  assign w_rd1 = (w_ra1 == 5'd0) ? 32'h0 : r_rf[w_ra1];
  assign w_rd2 = (w_ra2 == 5'd0) ? 32'h0 : r_rf[w_ra2];

  assign w_srcb = bus.alusrc ? w_signimm : w_rd2;

  always_comb begin
    w_alu = 32'h0;
    case (bus.alucontrol)
      ALU_AND: w_alu = w_rd1 & w_srcb;
      ALU_OR:  w_alu = w_rd1 | w_srcb;
      ALU_ADD: w_alu = w_rd1 + w_srcb;
      ALU_SUB: w_alu = w_rd1 - w_srcb;
      ALU_SLT: w_alu = ($signed(w_rd1) < $signed(w_srcb)) ? 32'h1 : 32'h0;
      ALU_NOR: w_alu = ~(w_rd1 | w_srcb);
      default: w_alu = 32'h0;
    endcase
  end

  assign w_result = bus.memtoreg ? bus.readdata : w_alu;

  assign w_pcplus4  = r_pc + 32'd4;
  assign w_pcbranch = w_pcplus4 + {w_signimm[29:0], 2'b00};
  assign w_pcjump   = {w_pcplus4[31:28], bus.instr[25:0], 2'b00};

  // Jump outranks branch when the controller raises both.
  always_comb begin
    w_pcnext = w_pcplus4;
    if (bus.jump)
      w_pcnext = w_pcjump;
    else if (bus.pcsrc)
      w_pcnext = w_pcbranch;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= 32'h0;
      for (int i = 0; i < 32; i++)
        r_rf[i] <= 32'h0;
    end else begin
      r_pc <= w_pcnext;
      if (bus.regwrite && (w_wa != 5'd0))
        r_rf[w_wa] <= w_result;
    end
  end

  assign bus.pc        = r_pc;
  assign bus.aluout    = w_alu;
  assign bus.zero      = (w_alu == 32'h0);
  assign bus.writedata = w_rd2;

endmodule

// File: tb/tb_mips_datapath.sv
// Self-checking bench for mips_datapath: a vector table of instructions with
// expected ALU/store/PC results, plus a mid-cycle reset sequence.
module tb_mips_datapath;

  logic clk;
  logic reset;

  mips_datapath_if dp_bus ();

  mips_datapath dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dp_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        regdst;
    logic        pcsrc;
    logic        memtoreg;
    logic        alusrc;
    logic        regwrite;
    logic        jump;
    logic [3:0]  aluc;
    logic [31:0] instr;
    logic [31:0] readdata;
    logic [31:0] exp_alu;
    logic        exp_zero;
    logic [31:0] exp_wd;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] alu;
    logic        zero;
    logic [31:0] wd;
    logic [31:0] pc;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb_q[$];
  vec_t vecs[21];

  function automatic vec_t mk(input logic rd, input logic ps, input logic m2r,
                              input logic as, input logic rw, input logic jp,
                              input logic [3:0] ac, input logic [31:0] ins,
                              input logic [31:0] rdat, input logic [31:0] ealu,
                              input logic ez, input logic [31:0] ewd,
                              input logic [31:0] epc);
    vec_t v;
    v.regdst = rd; v.pcsrc = ps; v.memtoreg = m2r; v.alusrc = as;
    v.regwrite = rw; v.jump = jp; v.aluc = ac; v.instr = ins;
    v.readdata = rdat; v.exp_alu = ealu; v.exp_zero = ez; v.exp_wd = ewd;
    v.exp_pc = epc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    dp_bus.regdst     = v.regdst;
    dp_bus.pcsrc      = v.pcsrc;
    dp_bus.memtoreg   = v.memtoreg;
    dp_bus.alusrc     = v.alusrc;
    dp_bus.regwrite   = v.regwrite;
    dp_bus.jump       = v.jump;
    dp_bus.alucontrol = v.aluc;
    dp_bus.instr      = v.instr;
    dp_bus.readdata   = v.readdata;
  endtask

  initial begin
    exp_t e;
    vec_t idle;

    //            rd ps m2r as rw jp aluc     instr         rdata         alu           z     wd            pc
    vecs[0]  = mk(0, 0, 0, 1, 1, 0, 4'b0010, 32'h20020005, 32'h0,        32'h00000005, 1'b0, 32'h0,        32'h04); // addi r2,r0,5
    vecs[1]  = mk(0, 0, 0, 1, 1, 0, 4'b0000, 32'h3044000F, 32'h0,        32'h00000005, 1'b0, 32'h0,        32'h08); // andi r4,r2,0xF
    vecs[2]  = mk(0, 0, 0, 1, 1, 0, 4'b0001, 32'h3445000A, 32'h0,        32'h0000000F, 1'b0, 32'h0,        32'h0C); // ori r5,r2,0xA
    vecs[3]  = mk(0, 0, 0, 1, 1, 0, 4'b0111, 32'h28460003, 32'h0,        32'h00000000, 1'b1, 32'h0,        32'h10); // slti r6,r2,3
    vecs[4]  = mk(0, 0, 0, 1, 1, 0, 4'b0111, 32'h2846FFFF, 32'h0,        32'h00000000, 1'b1, 32'h0,        32'h14); // slti r6,r2,-1
    vecs[5]  = mk(1, 0, 0, 0, 1, 0, 4'b0110, 32'h00421822, 32'h0,        32'h00000000, 1'b1, 32'h5,        32'h18); // sub r3,r2,r2
    vecs[6]  = mk(1, 0, 0, 0, 1, 0, 4'b0010, 32'h00420020, 32'h0,        32'h0000000A, 1'b0, 32'h5,        32'h1C); // add r0,r2,r2
    vecs[7]  = mk(1, 0, 0, 0, 1, 0, 4'b0001, 32'h00044025, 32'h0,        32'h00000005, 1'b0, 32'h5,        32'h20); // or r8,r0,r4
    vecs[8]  = mk(0, 0, 1, 1, 1, 0, 4'b0010, 32'h8C470004, 32'h0000000F, 32'h00000009, 1'b0, 32'h0,        32'h24); // lw r7,4(r2)
    vecs[9]  = mk(0, 0, 0, 1, 0, 0, 4'b0010, 32'hAC470004, 32'h0000DEAD, 32'h00000009, 1'b0, 32'hF,        32'h28); // sw r7,4(r2)
    vecs[10] = mk(1, 0, 0, 0, 0, 0, 4'b1100, 32'h00E54827, 32'h0,        32'hFFFFFFF0, 1'b0, 32'hF,        32'h2C); // nor r7,r5
    vecs[11] = mk(1, 0, 0, 0, 0, 0, 4'b0011, 32'h00470000, 32'h0,        32'h00000000, 1'b1, 32'hF,        32'h30); // undefined op
    vecs[12] = mk(1, 0, 0, 0, 0, 0, 4'b0110, 32'h00020022, 32'h0,        32'hFFFFFFFB, 1'b0, 32'h5,        32'h34); // 0 - 5 wraps
    vecs[13] = mk(0, 0, 0, 0, 0, 1, 4'b0000, 32'h08000002, 32'h0,        32'h00000000, 1'b1, 32'h0,        32'h08); // j 0x8
    vecs[14] = mk(0, 0, 0, 0, 0, 1, 4'b0000, 32'h08000001, 32'h0,        32'h00000000, 1'b1, 32'h0,        32'h04); // j 0x4
    vecs[15] = mk(0, 1, 0, 0, 0, 1, 4'b0000, 32'h08000004, 32'h0,        32'h00000000, 1'b1, 32'h0,        32'h10); // jump beats branch
    vecs[16] = mk(0, 1, 0, 0, 0, 0, 4'b0110, 32'h10420002, 32'h0,        32'h00000000, 1'b1, 32'h5,        32'h1C); // beq +2
    vecs[17] = mk(0, 0, 0, 0, 0, 1, 4'b0000, 32'h08000004, 32'h0,        32'h00000000, 1'b1, 32'h0,        32'h10); // j 0x10
    vecs[18] = mk(0, 1, 0, 0, 0, 0, 4'b0110, 32'h1042FFFF, 32'h0,        32'h00000000, 1'b1, 32'h5,        32'h10); // beq -1
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 4'b0110, 32'h10420002, 32'h0,        32'h00000000, 1'b1, 32'h5,        32'h14); // beq not taken
    vecs[20] = mk(0, 0, 0, 0, 0, 1, 4'b0000, 32'h08000004, 32'h0,        32'h00000000, 1'b1, 32'h0,        32'h10); // j 0x10

    idle = mk(0, 0, 0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0);
    reset = 1'b1;
    drive(idle);

    @(negedge clk);
    check("reset_pc", dut.bus.pc, 32'h0);
    check("reset_aluout", dp_bus.aluout, 32'h0);
    check("reset_zero", {31'h0, dp_bus.zero}, 32'h1);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      e.alu = vecs[i].exp_alu; e.zero = vecs[i].exp_zero;
      e.wd = vecs[i].exp_wd;   e.pc = vecs[i].exp_pc;
      sb_q.push_back(e);
      #1;
      e = sb_q.pop_front();
      check($sformatf("v%0d_aluout", i), dp_bus.aluout, e.alu);
      check($sformatf("v%0d_zero", i), {31'h0, dp_bus.zero}, {31'h0, e.zero});
      check($sformatf("v%0d_writedata", i), dp_bus.writedata, e.wd);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_pc", i), dp_bus.pc, e.pc);
      @(negedge clk);
    end

    // Mid-cycle reset at pc 0x10: r2 + r7 before, all-zero state after.
    drive(mk(1, 0, 0, 0, 0, 0, 4'b0010, 32'h00470020, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0));
    #1;
    check("pre_reset_pc", dp_bus.pc, 32'h10);
    check("pre_reset_aluout", dp_bus.aluout, 32'h14);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset_pc", dp_bus.pc, 32'h0);
    check("async_reset_aluout", dp_bus.aluout, 32'h0);
    check("async_reset_writedata", dp_bus.writedata, 32'h0);
    @(posedge clk);
    #1;
    check("held_reset_pc", dp_bus.pc, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_pc", dp_bus.pc, 32'h4);
    check("post_reset_regs", dp_bus.aluout, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_datapath.md
Name: mips_datapath

Overview:
- Single-cycle MIPS-style 32-bit datapath: PC register, next-PC logic (PC+4, branch, jump), 32x32 register file, sign extender, ALU and writeback mux.
- Instruction and data memories are external. The controller drives the control inputs combinationally from the same instruction.
- Sits between the control unit and the instruction/data memories in the top-level processor.

Parameters:
- none (fixed 32-bit data, 32 registers, 4-bit ALU control)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- regdst  in  1  write-register select: 1 = rd instr[15:11], 0 = rt instr[20:16]
- pcsrc  in  1  1 = take branch target
- memtoreg  in  1  writeback select: 1 = readdata, 0 = aluout
- alusrc  in  1  ALU B select: 1 = sign-extended immediate, 0 = rt register value
- regwrite  in  1  register file write enable
- jump  in  1  1 = take jump target (overrides pcsrc)
- alucontrol  in  4  ALU operation select
- instr  in  32  current instruction from instruction memory
- readdata  in  32  data-memory read data
- zero  out  1  1 when aluout == 0
- pc  out  32  current program counter (instruction-memory address)
- aluout  out  32  ALU result (data-memory address / writeback value)
- writedata  out  32  rt register value (data-memory store data)

Behaviour:
- Reset: asynchronous, active-high. While reset is high, PC = 0x00000000 and all 32 registers = 0. Reset is honoured mid-cycle with no clock required. Outputs are combinational from the reset state; e.g. aluout then equals ALU(0, srcb).
- Register file:
  - read addresses rs = instr[25:21], rt = instr[20:16]; reads are asynchronous
  - register 0 always reads 0; writes to it are ignored
  - write on rising clk when regwrite=1 and reset=0
  - write address = regdst ? instr[15:11] : instr[20:16]
  - result = memtoreg ? readdata : aluout
  - read-during-write in the same cycle returns the old value; the new value is visible after the edge
- signimm = {{16{instr[15]}}, instr[15:0]}.
- ALU:
  - srca = rs value; srcb = alusrc ? signimm : rt value
  - 0000 AND; 0001 OR; 0010 ADD (wraps mod 2^32, no overflow trap); 0110 SUB (srca - srcb, wraps); 0111 SLT (signed compare, result 1 or 0); 1100 NOR
  - all other codes give 0
- zero = (aluout == 32'h0).
- writedata = rt register value, independent of alusrc.
- Next PC:
  - pcplus4 = pc + 4
  - pcbranch = pcplus4 + (signimm << 2)
  - pcjump = {pcplus4[31:28], instr[25:0], 2'b00}
  - pcnext = jump ? pcjump : (pcsrc ? pcbranch : pcplus4)
  - PC loads pcnext on every rising clk when reset=0 (no stall input)
  - jump has priority over pcsrc; address arithmetic wraps mod 2^32
- Latency:
  - combinational path instr/readdata/control -> aluout/zero/writedata in the same cycle
  - register writes and PC update take effect at the next rising edge

Test Plan:
- Reset: assert reset asynchronously mid-cycle with PC = 0x10 -> PC becomes 0 immediately; registers read 0; release reset -> PC = 4 after first edge.
- ADDI r2,r0,5 (instr 0x20020005, alusrc=1, alucontrol=0010, regwrite=1, regdst=0) -> aluout = 5 same cycle; after edge r2 = 5 and pc += 4. Then ANDI r4,r2,0xF -> 5; ORI r5,r2,0xA -> 0xF; SLTI r6,r2,3 -> 0; SLTI with imm 0xFFFF (-1) -> 0.
- R-type SUB r3,r2,r2 (regdst=1, alusrc=0, alucontrol=0110) -> aluout = 0, zero = 1; writes to r0 leave r0 = 0.
- LW r7,4(r2): memtoreg=1, readdata = 0xF -> aluout = 9 (address); after edge r7 = 0xF. SW r7,4(r2), regwrite=0 -> aluout = 9, writedata = 0xF, no register changes.
- Jump: pc = 0x8, instr 0x08000001, jump=1 -> next pc = 0x4. With jump=1 and pcsrc=1 together, the jump target wins.
- BEQ offset 2 at pc = 0x10 with pcsrc=1 -> next pc = 0x1C; offset 0xFFFF -> next pc = 0x10; pcsrc=0 -> next pc = 0x14.
